// File: rtl/frame_read_ctrl_pkg.sv
// Shared types for the triple-buffer frame read controller.
//   state_e     : controller FSM states
//   bank_t      : frame-buffer bank index (0..NUM_BANKS-1)
//   other_bank  : returns the bank that is neither of the two given banks
package frame_read_ctrl_pkg;

    localparam int NUM_BANKS = 3;
    // Sum of all bank indices; subtracting two distinct banks leaves the third.
    localparam int BANK_SUM  = NUM_BANKS * (NUM_BANKS - 1) / 2;

    typedef logic [1:0] bank_t;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        CHECK,
        CMD,
        WAIT
    } state_e;

    function automatic bank_t other_bank(input bank_t a, input bank_t b);
        return bank_t'(BANK_SUM - int'(a) - int'(b));
    endfunction

endpackage

// File: rtl/frame_read_ctrl_if.sv
// Burst read command channel between the frame read controller and the
// frame-buffer memory read port.
//   rd_cmd_valid/rd_cmd_ready : command handshake
//   rd_cmd_addr               : burst start word address
//   rd_cmd_len                : burst length in words (1..BURST_LEN)
//   rd_burst_done             : pulse when the outstanding burst has landed in the FIFO
// master = controller side, slave = memory side.
interface frame_read_ctrl_if #(
    parameter int ADDR_WIDTH = 25,
    parameter int LEN_W      = 7
);
    logic                  rd_cmd_valid;
    logic                  rd_cmd_ready;
    logic [ADDR_WIDTH-1:0] rd_cmd_addr;
    logic [LEN_W-1:0]      rd_cmd_len;
    logic                  rd_burst_done;

    modport master (
        output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        input  rd_cmd_ready, rd_burst_done
    );

    modport slave (
        input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        output rd_cmd_ready, rd_burst_done
    );
endinterface

// File: rtl/frame_read_ctrl.sv
// Triple-buffer frame scheduler. Owns bank assignment for the frame writer
// and the frame reader so the display never reads the bank being written,
// and streams the selected bank out as FIFO-throttled burst read commands.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   read_req         : level request for a new frame, held until read_req_ack
//   read_req_ack     : one-cycle acknowledge
//   wr_frame_done    : writer finished the frame in wr_bank
//   wr_bank, rd_bank : bank assigned to the writer / currently being read
//   mem              : burst command channel (master side)
//   fifo_wr_count    : read FIFO fill level
//   busy             : frame in progress
//   underrun         : pulse when a new request arrives mid-frame
module frame_read_ctrl
    import frame_read_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 25,
    parameter int BANK_STRIDE = 2**21,
    parameter int FRAME_WORDS = 786432,
    parameter int BURST_LEN   = 64,
    parameter int FIFO_DEPTH  = 512
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        read_req,
    output logic                        read_req_ack,
    input  logic                        wr_frame_done,
    output bank_t                       wr_bank,
    output bank_t                       rd_bank,
    frame_read_ctrl_if.master           mem,
    input  logic [$clog2(FIFO_DEPTH):0] fifo_wr_count,
    output logic                        busy,
    output logic                        underrun
);

    localparam int LEN_W = $clog2(BURST_LEN) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REM_W = $clog2(FRAME_WORDS + 1);

    state_e                state_q, state_d;
    bank_t                 rd_bank_q, rd_bank_d;
    bank_t                 wr_bank_q, wr_bank_d;
    bank_t                 last_done_q, last_done_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REM_W-1:0]      remaining_q, remaining_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  ack_q, ack_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  underrun_q, underrun_d;
    logic                  pend_q, pend_d;

    logic [LEN_W-1:0]      next_len;
    logic [CNT_W:0]        fill_after;
    logic                  fits;
    logic                  in_frame;

    // Length of the burst CHECK would issue, and whether it fits in the FIFO.
    // Comparing fill+len against depth avoids an underflowing subtraction.
    assign next_len   = (remaining_q >= REM_W'(BURST_LEN)) ? LEN_W'(BURST_LEN)
                                                           : LEN_W'(remaining_q);
    assign fill_after = {1'b0, fifo_wr_count} + (CNT_W + 1)'(next_len);
    assign fits       = (fill_after <= (CNT_W + 1)'(FIFO_DEPTH));
    assign in_frame   = (state_q == CHECK) || (state_q == CMD) || (state_q == WAIT);

    // Bank rotation. A completed write always becomes last_done and the writer
    // moves to the bank nobody holds. On the ack cycle the reader takes
    // last_done, or the just-completed bank when both coincide; in both cases
    // the new rd_bank differs from the new wr_bank.
    always_comb begin
        rd_bank_d   = rd_bank_q;
        wr_bank_d   = wr_bank_q;
        last_done_d = last_done_q;
        if (wr_frame_done) begin
            last_done_d = wr_bank_q;
            wr_bank_d   = other_bank(rd_bank_q, wr_bank_q);
        end
        if (state_q == ACK) begin
            rd_bank_d = wr_frame_done ? wr_bank_q : last_done_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        len_d       = len_q;
        valid_d     = valid_q;
        pend_d      = pend_q;
        ack_d       = 1'b0;
        underrun_d  = 1'b0;

        // pend_q marks a restart request already reported, so a held
        // read_req raises underrun only once.
        if (in_frame && read_req && !pend_q) begin
            underrun_d = 1'b1;
            pend_d     = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (read_req) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
            end
            ACK: begin
                offset_d    = '0;
                remaining_d = REM_W'(FRAME_WORDS);
                pend_d      = 1'b0;
                state_d     = CHECK;
            end
            CHECK: begin
                if (read_req) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end else if (remaining_q == '0) begin
                    state_d = IDLE;
                end else if (fits) begin
                    state_d = CMD;
                    valid_d = 1'b1;
                    addr_d  = ADDR_WIDTH'(rd_bank_q) * ADDR_WIDTH'(BANK_STRIDE) + offset_q;
                    len_d   = next_len;
                end
            end
            CMD: begin
                if (mem.rd_cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem.rd_burst_done) begin
                    offset_d    = offset_q + ADDR_WIDTH'(len_q);
                    remaining_d = remaining_q - REM_W'(len_q);
                    if (pend_q) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_bank_q   <= bank_t'(1);
            wr_bank_q   <= bank_t'(0);
            last_done_q <= bank_t'(1);
            offset_q    <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            ack_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            wr_bank_q   <= wr_bank_d;
            last_done_q <= last_done_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            ack_q       <= ack_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
            pend_q      <= pend_d;
        end
    end

    assign read_req_ack     = ack_q;
    assign rd_bank          = rd_bank_q;
    assign wr_bank          = wr_bank_q;
    assign busy             = busy_q;
    assign underrun         = underrun_q;
    assign mem.rd_cmd_valid = valid_q;
    assign mem.rd_cmd_addr  = addr_q;
    assign mem.rd_cmd_len   = len_q;

endmodule
